// File: rtl/goertzel_tone_detector_if.sv
// goertzel_tone_detector_if: magnitude/threshold inputs and tone status outputs of the tone detector.
interface goertzel_tone_detector_if #(parameter int MAG_W = 16);
    logic [MAG_W-1:0] mag_in;
    logic             mag_rdy;
    logic [MAG_W-1:0] thr_on;
    logic [MAG_W-1:0] thr_off;
    logic             peak_clr;
    logic             tone_det;
    logic             det_rise;
    logic             det_fall;
    logic [MAG_W-1:0] mag_latched;
    logic [MAG_W-1:0] peak_mag;
    logic             stale;
    modport master (
        output mag_in, mag_rdy, thr_on, thr_off, peak_clr,
        input  tone_det, det_rise, det_fall, mag_latched, peak_mag, stale
    );
    modport slave (
        input  mag_in, mag_rdy, thr_on, thr_off, peak_clr,
        output tone_det, det_rise, det_fall, mag_latched, peak_mag, stale
    );
endinterface

// File: rtl/goertzel_tone_detector.sv
// goertzel_tone_detector: hysteresis + frame-debounced tone decision with peak hold and stale watchdog.
// Define GOERTZEL_DET_MAG_AVG_EN to smooth magnitudes with an exponential average (adds one cycle).
module goertzel_tone_detector #(
    parameter int MAG_W       = 16,
    parameter int HOLD_FRAMES = 3,
    parameter int TIMEOUT_CYC = 2400000,
    parameter int ALPHA_SH    = 2
) (
    input logic                     sys_clk,
    input logic                     sys_rst_n,
    goertzel_tone_detector_if.slave bus
);
    localparam int CNT_W = $clog2(HOLD_FRAMES + 1);
    localparam int WD_W  = $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_HOLD = CNT_W'(HOLD_FRAMES);
    localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [WD_W-1:0]  WD_FIRE  = WD_W'(TIMEOUT_CYC - 2);

    typedef enum logic [1:0] {S_IDLE, S_ARMING, S_DETECTED, S_RELEASING} state_t;

    if (HOLD_FRAMES < 1 || TIMEOUT_CYC < 2 || ALPHA_SH < 0 || ALPHA_SH >= MAG_W) begin : g_bad_cfg
        $error("goertzel_tone_detector: unsupported parameter set");
    end

    logic             r_v1;
    logic             r_stale;
    logic             r_tone;
    logic             r_rise;
    logic             r_fall;
    logic [MAG_W-1:0] r_mag;
    logic [MAG_W-1:0] r_on;
    logic [MAG_W-1:0] r_off;
    logic [MAG_W-1:0] r_peak;
    logic [WD_W-1:0]  r_wd;
    logic [CNT_W-1:0] r_cnt;
    state_t           r_state;
    logic [MAG_W-1:0] w_mag_nxt;
    logic [MAG_W-1:0] w_cmp_mag;
    logic [MAG_W-1:0] w_cmp_on;
    logic [MAG_W-1:0] w_cmp_off;
    logic             w_cmp_v;
    logic             w_hi;
    logic             w_lo;
    logic             w_done;
    logic             w_to;
    logic [CNT_W-1:0] w_cnt_inc;

`ifdef GOERTZEL_DET_MAG_AVG_EN
    logic signed [MAG_W:0] w_diff;
    logic signed [MAG_W:0] w_step;
    logic                  r_v2;
    logic [MAG_W-1:0]      r_mag2;
    logic [MAG_W-1:0]      r_on2;
    logic [MAG_W-1:0]      r_off2;

    // r_mag holds the running average; the sum wraps to MAG_W bits
    assign w_diff    = $signed({1'b0, bus.mag_in}) - $signed({1'b0, r_mag});
    assign w_step    = w_diff >>> ALPHA_SH;
    assign w_mag_nxt = MAG_W'($unsigned(w_step) + {1'b0, r_mag});

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_v2   <= 1'b0;
            r_mag2 <= '0;
            r_on2  <= '0;
            r_off2 <= '0;
        end else begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_mag2 <= r_mag;
                r_on2  <= r_on;
                r_off2 <= r_off;
            end
        end
    end

    assign w_cmp_v   = r_v2;
    assign w_cmp_mag = r_mag2;
    assign w_cmp_on  = r_on2;
    assign w_cmp_off = r_off2;
`else
    assign w_mag_nxt = bus.mag_in;
    assign w_cmp_v   = r_v1;
    assign w_cmp_mag = r_mag;
    assign w_cmp_on  = r_on;
    assign w_cmp_off = r_off;
`endif

    assign w_hi      = w_cmp_mag >= w_cmp_on;
    assign w_lo      = w_cmp_mag < w_cmp_off;
    assign w_cnt_inc = r_cnt + CNT_W'(1);
    assign w_done    = w_cnt_inc == CNT_HOLD;
    assign w_to      = !bus.mag_rdy && r_wd == WD_FIRE;

    // Off threshold is clamped to the on threshold so the band can never invert
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_v1  <= 1'b0;
            r_mag <= '0;
            r_on  <= '0;
            r_off <= '0;
        end else begin
            r_v1 <= bus.mag_rdy;
            if (bus.mag_rdy) begin
                r_mag <= w_mag_nxt;
                r_on  <= bus.thr_on;
                r_off <= (bus.thr_off < bus.thr_on) ? bus.thr_off : bus.thr_on;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_wd    <= '0;
            r_stale <= 1'b0;
        end else begin
            r_wd    <= bus.mag_rdy ? '0 : (r_wd == WD_MAX) ? WD_MAX : r_wd + WD_W'(1);
            r_stale <= bus.mag_rdy ? 1'b0 : (r_stale | w_to);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_tone  <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            if (w_to) begin
                r_state <= S_IDLE;
                r_cnt   <= '0;
                r_tone  <= 1'b0;
                r_fall  <= r_tone;
            end else if (w_cmp_v) begin
                case (r_state)
                    S_IDLE, S_ARMING: begin
                        if (w_hi) begin
                            r_state <= w_done ? S_DETECTED : S_ARMING;
                            r_cnt   <= w_done ? '0 : w_cnt_inc;
                            r_tone  <= w_done;
                            r_rise  <= w_done;
                        end else begin
                            r_state <= S_IDLE;
                            r_cnt   <= '0;
                        end
                    end
                    S_DETECTED, S_RELEASING: begin
                        if (w_lo) begin
                            r_state <= w_done ? S_IDLE : S_RELEASING;
                            r_cnt   <= w_done ? '0 : w_cnt_inc;
                            r_tone  <= !w_done;
                            r_fall  <= w_done;
                        end else begin
                            r_state <= S_DETECTED;
                            r_cnt   <= '0;
                        end
                    end
                endcase
            end
        end
    end

    // A clear coinciding with a frame leaves that frame's magnitude as the new peak
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) r_peak <= '0;
        else if (w_cmp_v && (bus.peak_clr || w_cmp_mag > r_peak)) r_peak <= w_cmp_mag;
        else if (bus.peak_clr) r_peak <= '0;
    end

    assign bus.tone_det    = r_tone;
    assign bus.det_rise    = r_rise;
    assign bus.det_fall    = r_fall;
    assign bus.mag_latched = r_mag;
    assign bus.peak_mag    = r_peak;
    assign bus.stale       = r_stale;
endmodule

// File: tb/tb_goertzel_tone_detector.sv
// tb_goertzel_tone_detector: directed + random frames checked every cycle against a frame-level model.
`timescale 1ns/1ps
module tb_goertzel_tone_detector;
    localparam int MAG_W = 16;
    localparam int HOLD  = 3;
    localparam int TMO   = 100;
    localparam int LAT   = 2;

    typedef struct {
        int left;
        int mag;
        int on;
        int off;
    } frame_t;

    logic   sys_clk = 1'b0;
    logic   sys_rst_n;
    int     checks = 0;
    int     failures = 0;
    int     cur_on = 1000;
    int     cur_off = 600;
    frame_t pipe[$];
    bit     det, e_tone, e_rise, e_fall, e_stale;
    bit     exp_ok = 1'b0;
    int     streak, idle, e_lat, e_peak;
    int     mode, mag, eff;
    bit     rdy, clr, rst_n;

    goertzel_tone_detector_if #(.MAG_W(MAG_W)) bus ();

    goertzel_tone_detector #(
        .MAG_W(MAG_W),
        .HOLD_FRAMES(HOLD),
        .TIMEOUT_CYC(TMO),
        .ALPHA_SH(2)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst_n(sys_rst_n),
        .bus(bus)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected outputs after the coming clock edge, from this cycle's inputs
    task automatic model(input bit m_rst_n, input bit m_rdy, input bit m_clr, input int m_mag);
        frame_t f;
        bit to;
        if (!m_rst_n) begin
            det = 0; streak = 0; idle = 0; pipe.delete();
            e_tone = 0; e_rise = 0; e_fall = 0; e_stale = 0; e_lat = 0; e_peak = 0;
            return;
        end
        e_rise = 0;
        e_fall = 0;
        to = 0;
        if (m_rdy) idle = 0;
        else if (idle < TMO - 1) begin
            idle++;
            to = (idle == TMO - 1);
        end
        foreach (pipe[i]) pipe[i].left = pipe[i].left - 1;
        if (m_clr) e_peak = 0;
        if (pipe.size() > 0 && pipe[0].left == 0) begin
            f = pipe.pop_front();
            if (f.mag > e_peak) e_peak = f.mag;
            if (!to && !det) begin
                streak = (f.mag >= f.on) ? streak + 1 : 0;
                if (streak == HOLD) begin det = 1; streak = 0; e_rise = 1; end
            end else if (!to) begin
                streak = (f.mag < f.off) ? streak + 1 : 0;
                if (streak == HOLD) begin det = 0; streak = 0; e_fall = 1; end
            end
        end
        if (to) begin
            e_fall = det;
            det = 0;
            streak = 0;
            e_stale = 1;
        end
        if (m_rdy) begin
            e_lat = m_mag;
            e_stale = 0;
            f.left = LAT - 1;
            f.mag = m_mag;
            f.on = cur_on;
            f.off = (cur_off < cur_on) ? cur_off : cur_on;
            pipe.push_back(f);
        end
        e_tone = det;
    endtask

    task automatic tick(input bit t_rst_n, input bit t_rdy, input bit t_clr, input int t_mag);
        @(negedge sys_clk);
        if (exp_ok) begin
            chk("tone_det", 32'(bus.tone_det), 32'(e_tone));
            chk("det_rise", 32'(bus.det_rise), 32'(e_rise));
            chk("det_fall", 32'(bus.det_fall), 32'(e_fall));
            chk("stale", 32'(bus.stale), 32'(e_stale));
            chk("mag_latched", 32'(bus.mag_latched), 32'(e_lat));
            chk("peak_mag", 32'(bus.peak_mag), 32'(e_peak));
        end
        sys_rst_n    = t_rst_n;
        bus.mag_rdy  = t_rdy;
        bus.peak_clr = t_clr;
        bus.mag_in   = 16'(t_mag);
        bus.thr_on   = 16'(cur_on);
        bus.thr_off  = 16'(cur_off);
        model(t_rst_n, t_rdy, t_clr, t_mag);
        exp_ok = exp_ok | !t_rst_n;
    endtask

    task automatic frame(input int f_mag, input int gap);
        tick(1, 1, 0, f_mag);
        repeat (gap) tick(1, 0, 0, 0);
    endtask

    initial begin
        sys_rst_n = 1'b0;
        bus.mag_rdy = 1'b0;
        bus.peak_clr = 1'b0;
        bus.mag_in = '0;
        bus.thr_on = '0;
        bus.thr_off = '0;
        repeat (3) tick(0, 0, 0, 0);
        chk("reset_tone", 32'(bus.tone_det), 32'd0);
        chk("reset_peak", 32'(bus.peak_mag), 32'd0);
        tick(1, 1, 0, 1500);
        repeat (20) tick(1, 0, 0, 0);
        tick(1, 1, 0, 1500);
        repeat (20) tick(1, 0, 0, 0);
        tick(1, 1, 0, 1500);
        tick(1, 0, 0, 0);
        chk("detect_not_early", 32'(bus.tone_det), 32'd0);
        tick(1, 0, 0, 0);
        chk("detect_at_k2", 32'(bus.tone_det), 32'd1);
        chk("rise_pulse", 32'(bus.det_rise), 32'd1);
        tick(1, 0, 0, 0);
        chk("rise_one_cycle", 32'(bus.det_rise), 32'd0);
        chk("plan_peak", 32'(bus.peak_mag), 32'd1500);
        repeat (3) frame(800, 20);
        chk("band_hold", 32'(bus.tone_det), 32'd1);
        repeat (3) frame(500, 20);
        chk("release", 32'(bus.tone_det), 32'd0);
        frame(1500, 5); frame(1500, 5); frame(900, 5); frame(1500, 5);
        chk("band_restart", 32'(bus.tone_det), 32'd0);
        frame(1500, 5); frame(1500, 5);
        chk("rearm", 32'(bus.tone_det), 32'd1);
        cur_off = 2000;
        frame(1200, 5);
        chk("eff_off_clamp", 32'(bus.tone_det), 32'd1);
        repeat (3) frame(900, 5);
        chk("eff_off_release", 32'(bus.tone_det), 32'd0);
        cur_off = 600;
        repeat (3) frame(1500, 3);
        repeat (TMO + 10) tick(1, 0, 0, 0);
        chk("timeout_stale", 32'(bus.stale), 32'd1);
        chk("timeout_tone", 32'(bus.tone_det), 32'd0);
        frame(100, 2);
        chk("stale_clear", 32'(bus.stale), 32'd0);
        tick(1, 1, 0, 300);
        repeat (LAT - 2) tick(1, 0, 0, 0);
        tick(1, 0, 1, 0);
        repeat (2) tick(1, 0, 0, 0);
        chk("peak_clr_load", 32'(bus.peak_mag), 32'd300);
        frame(1500, 3);
        tick(0, 0, 0, 0);
        tick(1, 0, 0, 0);
        chk("rst_mid_arm_peak", 32'(bus.peak_mag), 32'd0);
        chk("rst_mid_arm_lat", 32'(bus.mag_latched), 32'd0);
        frame(1500, 3); frame(1500, 3);
        chk("rst_clears_arming", 32'(bus.tone_det), 32'd0);
        mode = 0;
        for (int n = 0; n < 5000; n++) begin
            if (n % 50 == 0) mode = $urandom_range(0, 2);
            if ($urandom_range(0, 199) == 0) begin
                cur_on = $urandom_range(200, 3000);
                cur_off = $urandom_range(100, 3500);
            end
            eff = (cur_off < cur_on) ? cur_off : cur_on;
            mag = (mode == 0) ? int'($urandom_range(cur_on, cur_on + 2000)) :
                  (mode == 1) ? int'($urandom_range(0, eff - 1)) : int'($urandom_range(0, 65535));
            rdy = ($urandom_range(0, 3) == 0);
            clr = ($urandom_range(0, 39) == 0);
            rst_n = ($urandom_range(0, 1499) != 0);
            tick(rst_n, rdy, clr, mag);
            if ($urandom_range(0, 999) == 0) repeat ($urandom_range(90, 140)) tick(1, 0, 0, 0);
        end
        tick(1, 0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
